// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer, full / almost-full / level controller for the async FIFO.
// Optional sticky overflow flag is built when WPTR_OVERFLOW_FLAG_EN is defined.
module wptr_full_ctrl #(
    parameter int unsigned ADDRSIZE     = 4,
    parameter int unsigned AFULL_THRESH = (1 << ADDRSIZE) - 2
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    input  logic                winc,
    input  logic                wovf_clr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                walmost_full,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                woverflow
);

    localparam int unsigned PW = ADDRSIZE + 1;
    localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] wlevel_q, wlevel_d;
    logic          wfull_q, wfull_d;
    logic          wafull_q, wafull_d;
    logic          we_c;
    logic [PW-1:0] rbin_s;
    logic [PW-1:0] full_cmp_c;

    // Gray-to-binary of the synchronized read pointer: each bit is the XOR of itself and all higher bits
    always_comb begin
        rbin_s = '0;
        for (int i = 0; i < int'(PW); i++) begin
            rbin_s[i] = ^(wq2_rptr >> i);
        end
    end

    assign full_cmp_c = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};

    always_comb begin
        we_c     = winc & ~wfull_q;
        wbin_d   = wbin_q + PW'(we_c);
        wptr_d   = (wbin_d >> 1) ^ wbin_d;
        wlevel_d = wbin_d - rbin_s;
        wfull_d  = (wptr_d == full_cmp_c);
        wafull_d = (wlevel_d >= AFULL_LVL);
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin_q   <= '0;
            wptr_q   <= '0;
            wlevel_q <= '0;
            wfull_q  <= 1'b0;
            wafull_q <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wptr_q   <= wptr_d;
            wlevel_q <= wlevel_d;
            wfull_q  <= wfull_d;
            wafull_q <= wafull_d;
        end
    end

`ifdef WPTR_OVERFLOW_FLAG_EN
    logic wovf_q, wovf_d;

    // Set has priority over clear when both occur in one cycle
    always_comb begin
        wovf_d = wovf_q;
        if (winc & wfull_q) begin
            wovf_d = 1'b1;
        end else if (wovf_clr) begin
            wovf_d = 1'b0;
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wovf_q <= 1'b0;
        end else begin
            wovf_q <= wovf_d;
        end
    end

    assign woverflow = wovf_q;
`else
    logic unused_wovf_clr;
    assign unused_wovf_clr = wovf_clr;
    assign woverflow       = 1'b0;
`endif

    assign waddr        = wbin_q[ADDRSIZE-1:0];
    assign wptr         = wptr_q;
    assign wlevel       = wlevel_q;
    assign wfull        = wfull_q;
    assign walmost_full = wafull_q;

endmodule
